// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Optional trailing checksum check enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shreg_q, shreg_d;
    logic [31:0] len_q, len_d;
    logic [31:0] idx_q, idx_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic        xfer;
    logic        last;
    logic [31:0] word;

    assign rx_ready  = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign error     = err_q;

    assign xfer = rx_valid & rx_ready;
    assign last = (cnt_q == 2'd3);
    assign word = {rx_data, shreg_q};

    // Next-state: byte assembly, field completion and write issue
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        len_d   = len_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (xfer) begin
            shreg_d = word[31:8];
            cnt_d   = cnt_q + 2'd1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                    cnt_d   = 2'd0;
                    idx_d   = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 32'd0;
`endif
                end
            end
            S_LEN: begin
                if (xfer && last) begin
                    if (word > MAX_W) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = S_DATA;
                        len_d   = word;
                    end
                end
            end
            S_DATA: begin
                if (xfer && last) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + {idx_q[29:0], 2'b00};
                    wdata_d = word;
                    idx_d   = idx_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q + word;
`endif
                    if (idx_q == len_q - 32'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer && last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (word != csum_q) begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            shreg_q <= 24'd0;
            len_q   <= 32'd0;
            idx_q   <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed tests for the instruction-memory loader.
// Default build tests the plain path; IMEM_LOADER_CHECKSUM_EN adds checksum cases.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    int errors;
    int checks;
    int cyc;
    int last_acc;

    int          wr_n;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_cyc  [16];
    logic        wr_done [16];
    int          done_n;

    imem_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[wr_n[3:0]] <= mem_addr;
            wr_data[wr_n[3:0]] <= mem_wdata;
            wr_cyc[wr_n[3:0]]  <= cyc;
            wr_done[wr_n[3:0]] <= done;
            wr_n <= wr_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            if (rx_ready) begin
                last_acc = cyc;
                @(posedge clk);
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte timeout: byte %h not accepted, rx_ready=%b", b, rx_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[7:0]);
            t = t >> 8;
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_start();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b rx_ready=%b want 1 1", busy, rx_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error} !== 69'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b we=%b a=%h d=%h b=%b dn=%b e=%b want all 0",
                     rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b rx_ready=%b want 0 0", busy, rx_ready);
        end
    endtask

    task automatic test_two_word();
        int b;
        int a0;
        b = wr_n;
        do_start();
        send_word(32'd2);
        send_word(32'h4433_2211);
        a0 = last_acc;
        send_word(32'h8877_6655);
        end_stream();
        checks++;
        if (mem_we !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL two_word_end: we=%b done=%b busy=%b rdy=%b want 1 1 0 0",
                     mem_we, done, busy, rx_ready);
        end
        #1;
        checks++;
        if (wr_n - b !== 2) begin
            errors++;
            $display("FAIL two_word_count: got %0d writes want 2", wr_n - b);
        end
        checks++;
        if (wr_addr[b[3:0]] !== BASE || wr_data[b[3:0]] !== 32'h4433_2211) begin
            errors++;
            $display("FAIL two_word_w0: addr=%h data=%h want %h 44332211",
                     wr_addr[b[3:0]], wr_data[b[3:0]], BASE);
        end
        checks++;
        if (wr_cyc[b[3:0]] !== a0 + 1 || wr_done[b[3:0]] !== 1'b0) begin
            errors++;
            $display("FAIL two_word_lat: cyc=%0d done=%b want %0d 0",
                     wr_cyc[b[3:0]], wr_done[b[3:0]], a0 + 1);
        end
        checks++;
        if (wr_addr[(b + 1) & 15] !== BASE + 32'd4 || wr_data[(b + 1) & 15] !== 32'h8877_6655) begin
            errors++;
            $display("FAIL two_word_w1: addr=%h data=%h want %h 88776655",
                     wr_addr[(b + 1) & 15], wr_data[(b + 1) & 15], BASE + 32'd4);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== BASE + 32'd4) begin
            errors++;
            $display("FAIL two_word_after: done=%b we=%b addr=%h want 0 0 %h",
                     done, mem_we, mem_addr, BASE + 32'd4);
        end
    endtask

    task automatic test_zero_len();
        int b;
        b = wr_n;
        do_start();
        send_word(32'd0);
        end_stream();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: done=%b busy=%b err=%b we=%b want 1 0 0 0",
                     done, busy, error, mem_we);
        end
        #1;
        checks++;
        if (wr_n !== b) begin
            errors++;
            $display("FAIL zero_len_writes: got %0d writes want 0", wr_n - b);
        end
    endtask

    task automatic test_max_boundary();
        int b;
        b = wr_n;
        do_start();
        send_word(32'd4);
        for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + i);
        end_stream();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || mem_addr !== BASE + 32'd12 ||
            mem_wdata !== 32'hA000_0003) begin
            errors++;
            $display("FAIL max_len: done=%b err=%b addr=%h data=%h want 1 0 %h a0000003",
                     done, error, mem_addr, mem_wdata, BASE + 32'd12);
        end
        #1;
        checks++;
        if (wr_n - b !== 4) begin
            errors++;
            $display("FAIL max_len_count: got %0d writes want 4", wr_n - b);
        end
    endtask

    task automatic test_overflow();
        int b;
        int d;
        b = wr_n;
        d = done_n;
        do_start();
        send_word(32'd5);
        end_stream();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL overflow: err=%b busy=%b rdy=%b done=%b want 1 0 0 0",
                     error, busy, rx_ready, done);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        #1;
        checks++;
        if (wr_n !== b || done_n !== d || error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_quiet: writes=%0d dones=%0d err=%b busy=%b want 0 0 1 0",
                     wr_n - b, done_n - d, error, busy);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: err=%b want 0", error);
        end
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_stall_start();
        int b;
        int d;
        logic [31:0] w;
        b = wr_n;
        d = done_n;
        w = 32'hDEAD_BEEF;
        do_start();
        send_word(32'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[7:0]);
            w = w >> 8;
            if (i < 3) begin
                @(negedge clk);
                rx_valid = 1'b0;
                if (i == 1) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
            end
        end
        end_stream();
        checks++;
        if (done !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== BASE) begin
            errors++;
            $display("FAIL stall: done=%b we=%b data=%h addr=%h want 1 1 deadbeef %h",
                     done, mem_we, mem_wdata, mem_addr, BASE);
        end
        #1;
        checks++;
        if (wr_n - b !== 1 || done_n - d !== 1) begin
            errors++;
            $display("FAIL stall_count: writes=%0d dones=%0d want 1 1", wr_n - b, done_n - d);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        b = wr_n;
        do_start();
        send_word(32'd3);
        send_word(32'h1234_5678);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        checks++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error} !== 69'd0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b we=%b a=%h d=%h b=%b dn=%b e=%b want all 0",
                     rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error);
        end
        checks++;
        if (wr_n - b !== 1 || wr_data[b[3:0]] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_mid_w0: writes=%0d data=%h want 1 12345678",
                     wr_n - b, wr_data[b[3:0]]);
        end
        @(negedge clk);
        reset = 1'b1;
        b = wr_n;
        do_start();
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        end_stream();
        #1;
        checks++;
        if (wr_n - b !== 1 || wr_addr[b[3:0]] !== BASE || wr_data[b[3:0]] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL reset_reload: writes=%0d addr=%h data=%h want 1 %h cafef00d",
                     wr_n - b, wr_addr[b[3:0]], wr_data[b[3:0]], BASE);
        end
    endtask

    task automatic test_checksum(input logic [31:0] cs, input logic exp_err);
        do_start();
        send_word(32'd2);
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        send_word(cs);
        end_stream();
        checks++;
        if (done !== 1'b1 || error !== exp_err || busy !== 1'b0) begin
            errors++;
            $display("FAIL checksum %h: done=%b err=%b busy=%b want 1 %b 0",
                     cs, done, error, busy, exp_err);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        wr_n     = 0;
        done_n   = 0;
        last_acc = 0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        #1;
        test_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum(32'h0000_0000, 1'b0);
        test_checksum(32'h0000_0001, 1'b1);
`else
        test_two_word();
        test_zero_len();
        test_max_boundary();
        test_stall_start();
`endif
        test_overflow();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
